// File: rtl/car_pkg.sv
// Shared count-op encoding for the counter/address bank.
// Build option: CAR_SATURATE_EN selects saturating instead of modulo counting.
package car_pkg;

    typedef enum logic [1:0] {
        CNT_NONE = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // Exactly one of the active-low strobes asserted selects a direction.
    function automatic cnt_op_e car_decode_cnt(input logic inc_n, input logic dec_n);
        cnt_op_e op;
        op = CNT_NONE;
        if (!inc_n && dec_n) begin
            op = CNT_INC;
        end else if (inc_n && !dec_n) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/counter_address_cell.sv
// One counter/address register: load has priority over counting.
// Build option: CAR_SATURATE_EN holds the value at the boundary instead of wrapping.
module counter_address_cell
    import car_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  cnt_op_e          op,
    output logic [WIDTH-1:0] value,
    output logic             evt
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    function automatic logic at_boundary(input logic [WIDTH-1:0] v, input cnt_op_e o);
        return ((o == CNT_INC) && (&v)) || ((o == CNT_DEC) && (v == '0));
    endfunction

    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] v, input cnt_op_e o);
        logic [WIDTH-1:0] r;
        case (o)
            CNT_INC: r = v + 1'b1;
            CNT_DEC: r = v - 1'b1;
            default: r = v;
        endcase
`ifdef CAR_SATURATE_EN
        if (at_boundary(v, o)) begin
            r = v;
        end
`endif
        return r;
    endfunction

    always_comb begin
        value_d = value_q;
        evt     = 1'b0;
        if (load_en) begin
            value_d = load_data;
        end else begin
            value_d = next_count(value_q, op);
            evt     = at_boundary(value_q, op);
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/counter_address_bank.sv
// Bank of counter/address registers sharing a tri-state data bus and address bus.
// Build option: CAR_SATURATE_EN makes every channel saturate instead of wrap.
module counter_address_bank
    import car_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clock,
    input  logic             clear_n,
    inout  wire  [WIDTH-1:0] Bus,
    output logic [WIDTH-1:0] Addr,
    input  logic             load_n,
    input  logic [SEL_W-1:0] load_sel,
    input  logic             inc_n,
    input  logic             dec_n,
    input  logic [SEL_W-1:0] cnt_sel,
    input  logic             a_bus_n,
    input  logic [SEL_W-1:0] bus_sel,
    input  logic             a_addr_n,
    input  logic [SEL_W-1:0] addr_sel,
    output logic             wrap
);

    logic [WIDTH-1:0]    cell_val [CHANNELS];
    logic [CHANNELS-1:0] cell_evt;
    logic [CHANNELS-1:0] load_en;
    cnt_op_e             cell_op [CHANNELS];
    cnt_op_e             op;
    logic [WIDTH-1:0]    bus_val;
    logic [WIDTH-1:0]    addr_val;
    logic                bus_hit;
    logic                addr_hit;
    logic [WIDTH-1:0]    load_data;
    logic                wrap_q;
    logic                wrap_d;

    assign op = car_decode_cnt(inc_n, dec_n);

    // Out-of-range selects match no channel, so they neither update nor drive.
    always_comb begin
        load_en  = '0;
        bus_val  = '0;
        addr_val = '0;
        bus_hit  = 1'b0;
        addr_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            load_en[i] = !load_n && (load_sel == SEL_W'(i));
            cell_op[i] = (cnt_sel == SEL_W'(i)) ? op : CNT_NONE;
            if (bus_sel == SEL_W'(i)) begin
                bus_val = cell_val[i];
                bus_hit = 1'b1;
            end
            if (addr_sel == SEL_W'(i)) begin
                addr_val = cell_val[i];
                addr_hit = 1'b1;
            end
        end
    end

    assign Bus  = (!a_bus_n && bus_hit) ? bus_val : {WIDTH{1'bz}};
    assign Addr = (!a_addr_n && addr_hit) ? addr_val : {WIDTH{1'bz}};

    // Internal transfers take the source straight from the mux rather than the pad.
    assign load_data = (!a_bus_n && bus_hit) ? bus_val : Bus;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
        counter_address_cell #(.WIDTH(WIDTH)) u_cell (
            .clock     (clock),
            .clear_n   (clear_n),
            .load_en   (load_en[g]),
            .load_data (load_data),
            .op        (cell_op[g]),
            .value     (cell_val[g]),
            .evt       (cell_evt[g])
        );
    end

    assign wrap_d = |cell_evt;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: doc/counter_address_bank.md
# counter_address_bank

Parametrised bank of CHANNELS independent WIDTH-bit counter/address registers sharing one data bus and one address bus. Each channel loads from Bus, increments or decrements, and drives Bus or Addr through tri-state outputs. Register-to-register transfer completes in one cycle, and Addr output during a count gives post-increment/decrement addressing. Used as the CPU's PC/SP/index pointer group, replacing per-pointer single-channel counter registers.

## Interface
- WIDTH, 16, register and bus width
- CHANNELS, 4, number of registers (≥2); SEL_W = $clog2(CHANNELS) is derived and not overridable
- clock  input  1  rising-edge clock
- clear_n  input  1  asynchronous, active-low reset; all registers cleared
- Bus  inout  WIDTH  data bus; driven only while a_bus_n=0
- Addr  output  WIDTH  address bus; tri-state, driven only while a_addr_n=0
- load_n  input  1  active-low; load Bus into channel load_sel
- load_sel  input  SEL_W  load target
- inc_n  input  1  active-low; increment channel cnt_sel
- dec_n  input  1  active-low; decrement channel cnt_sel
- cnt_sel  input  SEL_W  count target
- a_bus_n  input  1  active-low; drive channel bus_sel onto Bus
- bus_sel  input  SEL_W
- a_addr_n  input  1  active-low; drive channel addr_sel onto Addr
- addr_sel  input  SEL_W
- wrap  output  1  registered one-cycle pulse on counter boundary event

## Operation
- Reset (clear_n=0, asynchronous): all registers 0, wrap 0. Bus and Addr follow their enables combinationally, so they show Z while enables are high.
- Load: at posedge with load_n=0, reg[load_sel] <= Bus. An undriven Bus (Z/X) loads X; this is the caller's responsibility.
- Count op per cycle: inc_n=0 and dec_n=1 gives +1; dec_n=0 and inc_n=1 gives −1; both low or both high gives no change.
- Counting uses modulo 2^WIDTH: 0xFFFF+1 gives 0x0000, and 0x0000−1 gives 0xFFFF.
- wrap <= 1 for exactly one cycle after a count crosses a boundary (inc from all-ones, dec from zero); otherwise 0.
- Same-channel conflict: if load_sel==cnt_sel and both are active, the load wins, the count is dropped, and wrap stays 0.
- Different channels: load and count proceed in the same cycle independently.
- Transfer: a_bus_n=0 (bus_sel=S) and load_n=0 (load_sel=D) copies reg[S] to reg[D] at the edge. S==D leaves the value unchanged.
- Post-increment addressing: a_addr_n=0 with addr_sel==cnt_sel and a count active presents the pre-count value on Addr; the register updates at the edge.
- Bus and Addr drive are independent; both may be enabled at once, with the same or different channels.
- Out-of-range select (≥CHANNELS, non-power-of-2 CHANNELS): a load or count is ignored, and a drive outputs Z.

## Timing
- Load/count latency: 1 cycle; the new value is visible on an enabled Bus/Addr after the edge.
- Output drive: combinational from enable, select and register (no clock); Z when not enabled.
- wrap: registered, asserted the cycle after the boundary event.
- clear_n asserted mid-operation overrides any load/count immediately. Deassertion is expected synchronous to clock. The first edge after release applies normal operation.

## Configuration
- CAR_SATURATE_EN defined: counting saturates. inc at all-ones and dec at zero hold the value, and wrap pulses to report the saturation event.
- CAR_SATURATE_EN undefined: modulo wrap as above.
- Load/transfer behaviour is identical in both builds.

## Structure
- Package car_pkg: count-op enum (CNT_NONE, CNT_INC, CNT_DEC) and the helper function that decodes inc_n/dec_n into it.
- Sub-module counter_address_cell: one WIDTH-bit register with load/count-op inputs and a wrap event output.
- Top: select decode, per-cell enables, tri-state output muxes, wrap register (OR of cell events).

## Test plan
- Reset then load: clear_n=0, load_n=0 with Bus=0xAAAA → reg0 stays 0. Release, load ch1 with 0xAAAA → Addr=0xAAAA with a_addr_n=0, addr_sel=1.
- Dec/inc: ch1=0xAAAA, two dec cycles → 0xAAA8 on Bus. Three inc cycles → 0xAAAB, and wrap stays 0.
- Wrap, without the macro: ch2=0xFFFF, inc → 0x0000 with wrap=1 for one cycle. ch2=0, dec → 0xFFFF with wrap=1.
- Saturation, with CAR_SATURATE_EN: ch2=0xFFFF, inc → 0xFFFF with wrap=1. ch2=0, dec → 0x0000 with wrap=1.
- Transfer and post-increment: ch1=0x1234, bus_sel=1, load_sel=3 → ch3=0x1234. Then inc ch3 with addr_sel=3 → Addr=0x1234 that cycle and 0x1235 the next.
- Conflicts: load 0x0055 and inc on the same channel → 0x0055. inc_n=dec_n=0 → value unchanged. Mid-count clear_n pulse → all channels 0 immediately.
